// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the parametrised LFSR generator.
// Holds the form selectors, common primitive polynomials and the Galois mask builder.
package lfsr_pkg;

  localparam int MODE_FIBONACCI = 0;
  localparam int MODE_GALOIS    = 1;

  // Widest state the mask helper can describe.
  localparam int MAX_W = 64;

  localparam logic [3:0]  POLY_4  = 4'hC;
  localparam logic [7:0]  POLY_8  = 8'hB8;
  localparam logic [15:0] POLY_16 = 16'hB400;
  localparam logic [31:0] POLY_32 = 32'h80200003;

  // The low WIDTH bits of the result are {taps[WIDTH-2:0], 1'b1} for any WIDTH <= MAX_W.
  function automatic logic [MAX_W-1:0] galois_mask(input logic [MAX_W-1:0] taps);
    return {taps[MAX_W-2:0], 1'b1};
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational single LFSR step in Fibonacci or Galois form.
// Produces the successor state and the bit shifted out of the MSB.
module lfsr_step
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
  parameter int               MODE  = MODE_FIBONACCI
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] next_o,
  output logic             bit_o
);

  assign bit_o = state_i[WIDTH-1];

  if (MODE == MODE_GALOIS) begin : g_galois
    localparam logic [MAX_W-1:0] GMASK_FULL = galois_mask(MAX_W'(TAPS));
    localparam logic [WIDTH-1:0] GMASK      = GMASK_FULL[WIDTH-1:0];
    assign next_o = {state_i[WIDTH-2:0], 1'b0} ^ (bit_o ? GMASK : '0);
  end else begin : g_fib
    assign next_o = {state_i[WIDTH-2:0], ^(state_i & TAPS)};
  end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR generator: STEPS chained steps per enabled clock, seed load with
// zero-seed rejection, all-zero lockup recovery and a wrap pulse on returning to the seed.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH    = 16,
  parameter logic [WIDTH-1:0] TAPS     = 16'hB400,
  parameter logic [WIDTH-1:0] RST_SEED = 16'h1001,
  parameter int               MODE     = MODE_FIBONACCI,
  parameter int               STEPS    = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] lfsr,
  output logic [STEPS-1:0] out_bits,
  output logic             wrap,
  output logic             seed_err
);

  if (WIDTH < 3 || WIDTH > MAX_W) begin : g_chk_width
    $fatal(1, "lfsr_gen: WIDTH must be in 3..%0d", MAX_W);
  end
  if (STEPS < 1 || STEPS > WIDTH) begin : g_chk_steps
    $fatal(1, "lfsr_gen: STEPS must be in 1..WIDTH");
  end
  if (RST_SEED == '0) begin : g_chk_seed
    $fatal(1, "lfsr_gen: RST_SEED must be non-zero");
  end
  if (TAPS[WIDTH-1] != 1'b1) begin : g_chk_taps
    $fatal(1, "lfsr_gen: TAPS[WIDTH-1] must be set");
  end
  if (MODE != MODE_FIBONACCI && MODE != MODE_GALOIS) begin : g_chk_mode
    $fatal(1, "lfsr_gen: MODE must be 0 or 1");
  end

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic [STEPS-1:0] out_bits_q, out_bits_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic [STEPS:0][WIDTH-1:0] chain;
  logic [STEPS-1:0]          step_bits;

  assign chain[0] = lfsr_q;

  // Step i emits the (i+1)-th outgoing bit, so the first bit lands in the MSB of out_bits.
  for (genvar i = 0; i < STEPS; i++) begin : g_step
    lfsr_step #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .MODE  (MODE)
    ) u_step (
      .state_i (chain[i]),
      .next_o  (chain[i+1]),
      .bit_o   (step_bits[STEPS-1-i])
    );
  end

  always_comb begin
    lfsr_d     = lfsr_q;
    seed_d     = seed_q;
    out_bits_d = out_bits_q;
    wrap_d     = 1'b0;
    err_d      = 1'b0;
    if (load) begin
      if (load_data != '0) begin
        lfsr_d = load_data;
        seed_d = load_data;
      end else begin
        lfsr_d = RST_SEED;
        seed_d = RST_SEED;
        err_d  = 1'b1;
      end
    end else if (lfsr_q == '0) begin
      // Recovery from an upset into the dead state; the active seed is kept.
      lfsr_d = RST_SEED;
      err_d  = 1'b1;
    end else if (enable) begin
      lfsr_d     = chain[STEPS];
      out_bits_d = step_bits;
      wrap_d     = (chain[STEPS] == seed_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q     <= RST_SEED;
      seed_q     <= RST_SEED;
      out_bits_q <= '0;
      wrap_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      lfsr_q     <= lfsr_d;
      seed_q     <= seed_d;
      out_bits_q <= out_bits_d;
      wrap_q     <= wrap_d;
      err_q      <= err_d;
    end
  end

  assign lfsr     = lfsr_q;
  assign out_bits = out_bits_q;
  assign wrap     = wrap_q;
  assign seed_err = err_q;

endmodule
